// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit controller: opcodes,
// controller state encoding and the divide-by-zero LO pattern.
// Optional macro: MDU_MUL_MC_EN (adds the registered-multiplier state).
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DIV_BUSY = 2'd1
`ifdef MDU_MUL_MC_EN
    ,
    ST_MUL_BUSY = 2'd2
`endif
  } mdu_state_e;

  // LO value written when a division by zero is requested.
  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

  // True for both signed and unsigned divide opcodes.
  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_mul.sv
// 32x32 -> 64 multiplier with signed/unsigned select.
// With MDU_MUL_MC_EN the product is registered (loaded while load_i is high),
// otherwise the product is purely combinational.
module mdu_mul
  import mdu_pkg::*;
(
`ifdef MDU_MUL_MC_EN
  input  logic        clk,
  input  logic        load_i,
`endif
  input  logic        signed_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] prod_o
);

  logic signed [32:0] a_ext;
  logic signed [32:0] b_ext;
  logic signed [63:0] prod_full;

  // Operands widened to 33 bits so one signed multiplier serves both modes;
  // the product only needs its low 64 bits.
  assign a_ext     = {signed_i & a_i[31], a_i};
  assign b_ext     = {signed_i & b_i[31], b_i};
  assign prod_full = 64'(a_ext) * 64'(b_ext);

`ifdef MDU_MUL_MC_EN
  logic [63:0] prod_q;

  // Product register: datapath only, consumed one cycle after the request.
  always_ff @(posedge clk) begin
    if (load_i) prod_q <= prod_full;
  end

  assign prod_o = prod_q;
`else
  assign prod_o = prod_full;
`endif

endmodule

// File: rtl/mdu_ctrl.sv
// MDU controller: sequences MULT/MULTU/DIV/DIVU/MTHI/MTLO, drives HI/LO
// writes and pipeline stall, and owns the start/cancel/done handshake with
// an external iterative divider.
// Optional macro: MDU_MUL_MC_EN (multiplier takes one extra cycle).
module mdu_ctrl
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [2:0]  op,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  input  logic        flush,
  input  logic [63:0] hilo_i,
  output logic        hilo_we,
  output logic [63:0] hilo_wdata,
  output logic        stall_o,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic        div_cancel,
  input  logic        div_done,
  input  logic [63:0] div_result
);

  mdu_state_e  state_q, state_d;
  logic [31:0] div_a_q, div_b_q;
  logic        div_signed_q;
  logic [63:0] mul_prod;

  mdu_mul u_mul (
`ifdef MDU_MUL_MC_EN
    .clk      (clk),
    .load_i   (state_q == ST_IDLE),
`endif
    .signed_i (op == OP_MULT),
    .a_i      (opa),
    .b_i      (opb),
    .prod_o   (mul_prod)
  );

  // Controller state register; reset returns to IDLE immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Divider operands captured on start and held for the whole division.
  always_ff @(posedge clk) begin
    if (div_start) begin
      div_a_q      <= opa;
      div_b_q      <= opb;
      div_signed_q <= div_signed;
    end
  end

  // Next-state and output decode; everything is forced low while in reset.
  always_comb begin
    state_d    = state_q;
    hilo_we    = 1'b0;
    hilo_wdata = '0;
    stall_o    = 1'b0;
    div_start  = 1'b0;
    div_signed = 1'b0;
    div_a      = '0;
    div_b      = '0;
    div_cancel = 1'b0;
    if (rst) begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid && !flush) begin
            if (is_div_op(op)) begin
              if (opb != '0) begin
                div_start  = 1'b1;
                stall_o    = 1'b1;
                div_a      = opa;
                div_b      = opb;
                div_signed = (op == OP_DIV);
                state_d    = ST_DIV_BUSY;
              end else begin
                hilo_we    = 1'b1;
                hilo_wdata = {opa, DIV0_LO};
              end
            end else if (op == OP_MULT || op == OP_MULTU) begin
`ifdef MDU_MUL_MC_EN
              stall_o = 1'b1;
              state_d = ST_MUL_BUSY;
`else
              hilo_we    = 1'b1;
              hilo_wdata = mul_prod;
`endif
            end else if (op == OP_MTHI) begin
              hilo_we    = 1'b1;
              hilo_wdata = {opa, hilo_i[31:0]};
            end else if (op == OP_MTLO) begin
              hilo_we    = 1'b1;
              hilo_wdata = {hilo_i[63:32], opa};
            end
          end
        end
        ST_DIV_BUSY: begin
          div_a      = div_a_q;
          div_b      = div_b_q;
          div_signed = div_signed_q;
          if (flush) begin
            // Killed instruction: abort divider, drop any coincident result.
            div_cancel = 1'b1;
            state_d    = ST_IDLE;
          end else if (div_done) begin
            hilo_we    = 1'b1;
            hilo_wdata = div_result;
            state_d    = ST_IDLE;
          end else begin
            stall_o = 1'b1;
          end
        end
`ifdef MDU_MUL_MC_EN
        ST_MUL_BUSY: begin
          state_d = ST_IDLE;
          if (!flush) begin
            hilo_we    = 1'b1;
            hilo_wdata = mul_prod;
          end
        end
`endif
        default: state_d = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed scenarios plus randomized
// operations against a behavioural model; the bench also plays the divider.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] opa = '0, opb = '0;
  logic        flush = 1'b0;
  logic [63:0] hilo_i = '0;
  logic        hilo_we;
  logic [63:0] hilo_wdata;
  logic        stall_o;
  logic        div_start, div_signed, div_cancel;
  logic [31:0] div_a, div_b;
  logic        div_done = 1'b0;
  logic [63:0] div_result = '0;

  int n_chk = 0;
  int n_err = 0;

`ifdef MDU_MUL_MC_EN
  localparam bit MC = 1'b1;
`else
  localparam bit MC = 1'b0;
`endif

  mdu_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .op         (op),
    .opa        (opa),
    .opb        (opb),
    .flush      (flush),
    .hilo_i     (hilo_i),
    .hilo_we    (hilo_we),
    .hilo_wdata (hilo_wdata),
    .stall_o    (stall_o),
    .div_start  (div_start),
    .div_signed (div_signed),
    .div_a      (div_a),
    .div_b      (div_b),
    .div_cancel (div_cancel),
    .div_done   (div_done),
    .div_result (div_result)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", n_chk);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference results computed with plain arithmetic.
  function automatic logic [63:0] ref_mul(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = longint'(a);
    ub = longint'(b);
    return 64'(ua * ub);
  endfunction

  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    int sa, sb, q, r;
    if (sgn) begin
      sa = $signed(a);
      sb = $signed(b);
      q  = sa / sb;
      r  = sa % sb;
      return {32'(r), 32'(q)};
    end
    return {a % b, a / b};
  endfunction

  task automatic quiet_chk(input string tag);
    chk({tag, "_we"},     64'(hilo_we),    64'd0);
    chk({tag, "_stall"},  64'(stall_o),    64'd0);
    chk({tag, "_start"},  64'(div_start),  64'd0);
    chk({tag, "_cancel"}, 64'(div_cancel), 64'd0);
  endtask

  // One complete operation. Entered and left at posedge+1.
  // lat: busy cycle on which the divider reports done.
  // fl_cyc: busy cycle on which flush is raised (0 = never).
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] hl, input logic fl_req, input int lat,
                        input int fl_cyc, input logic [63:0] exp_div);
    logic isdiv, ismul, go, e_start, e_we, e_stall, done_now, fl_now, ended;
    logic [63:0] e_w, mulp;
    isdiv   = (o == 3'd3) || (o == 3'd4);
    ismul   = (o == 3'd1) || (o == 3'd2);
    go      = !fl_req;
    mulp    = ref_mul(o == 3'd1, a, b);
    e_start = go && isdiv && (b != 0);
    e_we    = go && ((isdiv && b == 0) || o == 3'd5 || o == 3'd6 || (ismul && !MC));
    e_stall = e_start || (go && ismul && MC);
    case (o)
      3'd5:    e_w = {a, hl[31:0]};
      3'd6:    e_w = {hl[63:32], a};
      3'd1, 3'd2: e_w = mulp;
      default: e_w = {a, 32'hFFFF_FFFF};
    endcase
    // request cycle
    req_valid = 1'b1; op = o; opa = a; opb = b; hilo_i = hl; flush = fl_req; div_done = 1'b0;
    #1;
    chk("req_start", 64'(div_start), 64'(e_start));
    chk("req_we",    64'(hilo_we),   64'(e_we));
    chk("req_stall", 64'(stall_o),   64'(e_stall));
    if (e_we) chk("req_wdata", hilo_wdata, e_w);
    if (e_start) begin
      chk("req_div_a",   64'(div_a),      64'(a));
      chk("req_div_b",   64'(div_b),      64'(b));
      chk("req_div_sgn", 64'(div_signed), 64'(o == 3'd3));
    end
    @(posedge clk); #1;
    if (e_start) begin
      ended = 1'b0;
      for (int cyc = 1; cyc <= 64 && !ended; cyc++) begin
        done_now = (cyc == lat);
        fl_now   = (cyc == fl_cyc);
        // A competing request must be ignored while busy.
        req_valid = 1'b1; op = 3'd3; opa = $urandom | 32'd1; opb = $urandom | 32'd1;
        div_done = done_now; flush = fl_now;
        div_result = done_now ? exp_div : {$urandom, $urandom};
        #1;
        chk("busy_start",   64'(div_start),  64'd0);
        chk("busy_div_a",   64'(div_a),      64'(a));
        chk("busy_div_b",   64'(div_b),      64'(b));
        chk("busy_div_sgn", 64'(div_signed), 64'(o == 3'd3));
        chk("busy_cancel",  64'(div_cancel), 64'(fl_now));
        chk("busy_we",      64'(hilo_we),    64'(done_now && !fl_now));
        chk("busy_stall",   64'(stall_o),    64'(!done_now && !fl_now));
        if (done_now && !fl_now) chk("busy_wdata", hilo_wdata, exp_div);
        ended = done_now || fl_now;
        @(posedge clk); #1;
        if (cyc == 64 && !ended) chk("busy_bound", 64'(ended), 64'd1);
      end
      if (fl_cyc != 0 && fl_cyc < lat) begin
        // Late done from the cancelled division must be ignored.
        for (int k = 1; k <= 5; k++) begin
          req_valid = 1'b0; flush = 1'b0; div_done = (k == 5);
          div_result = {$urandom, $urandom};
          #1;
          quiet_chk("stale");
          @(posedge clk); #1;
        end
      end
    end else if (go && ismul && MC) begin
      fl_now = (fl_cyc != 0);
      req_valid = 1'b1; op = 3'd5; opa = $urandom; flush = fl_now;
      #1;
      chk("mulbusy_we",    64'(hilo_we), 64'(!fl_now));
      chk("mulbusy_stall", 64'(stall_o), 64'd0);
      if (!fl_now) chk("mulbusy_wdata", hilo_wdata, mulp);
      @(posedge clk); #1;
    end
    req_valid = 1'b0; flush = 1'b0; div_done = 1'b0;
    #1;
    quiet_chk("idle");
    @(posedge clk); #1;
  endtask

  initial begin
    logic [2:0]  o;
    logic [31:0] a, b;
    logic [63:0] hl;
    logic        fr;
    int          lat, fc;

    // Reset state, with an active DIV request that must not leak out.
    rst = 1'b0; req_valid = 1'b1; op = 3'd3; opa = 32'd50; opb = 32'd5;
    @(posedge clk); #1;
    chk("rst_stall",  64'(stall_o),    64'd0);
    chk("rst_we",     64'(hilo_we),    64'd0);
    chk("rst_wdata",  hilo_wdata,      64'd0);
    chk("rst_start",  64'(div_start),  64'd0);
    chk("rst_cancel", 64'(div_cancel), 64'd0);
    chk("rst_sgn",    64'(div_signed), 64'd0);
    chk("rst_div_a",  64'(div_a),      64'd0);
    chk("rst_div_b",  64'(div_b),      64'd0);
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Signed divide, done on busy cycle 33.
    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 64'd0, 1'b0, 33, 0, 64'hFFFFFFFF_FFFFFFFD);
    // Divide by zero.
    run_op(3'd4, 32'd100, 32'd0, 64'd0, 1'b0, 1, 0, 64'd0);
    chk("div0_const", {32'd100, 32'hFFFF_FFFF}, 64'h00000064_FFFFFFFF);
    // Multiplies.
    chk("mult_ref",  ref_mul(1'b1, 32'hFFFF_FFFE, 32'd3), 64'hFFFFFFFF_FFFFFFFA);
    chk("multu_ref", ref_mul(1'b0, 32'hFFFF_FFFE, 32'd3), 64'h00000002_FFFFFFFA);
    run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 64'd0, 1'b0, 1, 0, 64'd0);
    run_op(3'd2, 32'hFFFF_FFFE, 32'd3, 64'd0, 1'b0, 1, 0, 64'd0);
    // Flush at busy cycle 10, stale done 5 cycles later.
    run_op(3'd3, 32'd1000, 32'd7, 64'd0, 1'b0, 15, 10, ref_div(1'b1, 32'd1000, 32'd7));
    // MTHI / MTLO.
    run_op(3'd5, 32'h1234_5678, 32'd0, 64'hAAAAAAAA_BBBBBBBB, 1'b0, 1, 0, 64'd0);
    run_op(3'd6, 32'h1234_5678, 32'd0, 64'hAAAAAAAA_BBBBBBBB, 1'b0, 1, 0, 64'd0);
    // Flush in the request cycle.
    run_op(3'd4, 32'd9, 32'd3, 64'd0, 1'b1, 1, 0, 64'd0);

    // Reset at busy cycle 5 of a division.
    req_valid = 1'b1; op = 3'd3; opa = 32'd1000; opb = 32'd7; flush = 1'b0;
    @(posedge clk); #1;
    for (int c = 1; c < 5; c++) begin
      req_valid = 1'b0;
      @(posedge clk); #1;
    end
    req_valid = 1'b1; op = 3'd3; opa = 32'd77; opb = 32'd11;
    #1;
    chk("mid_pre_stall", 64'(stall_o), 64'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_stall",  64'(stall_o),    64'd0);
    chk("mid_rst_we",     64'(hilo_we),    64'd0);
    chk("mid_rst_wdata",  hilo_wdata,      64'd0);
    chk("mid_rst_start",  64'(div_start),  64'd0);
    chk("mid_rst_cancel", 64'(div_cancel), 64'd0);
    chk("mid_rst_sgn",    64'(div_signed), 64'd0);
    chk("mid_rst_div_a",  64'(div_a),      64'd0);
    chk("mid_rst_div_b",  64'(div_b),      64'd0);
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    quiet_chk("post_rst");
    @(posedge clk); #1;
    run_op(3'd4, 32'd200, 32'd9, 64'd0, 1'b0, 4, 0, ref_div(1'b0, 32'd200, 32'd9));

    // Randomized operations.
    for (int it = 0; it < 120; it++) begin
      o   = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 20));
      if (o == 3'd3 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
      hl  = {$urandom, $urandom};
      fr  = ($urandom_range(0, 7) == 0);
      lat = $urandom_range(1, 8);
      fc  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, lat) : 0;
      run_op(o, a, b, hl, fr, lat, fc,
             (b != 0) ? ref_div(o == 3'd3, a, b) : 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
